// File: rtl/avi_info_frame_receiver.sv
// AVI InfoFrame sink parser: checks header and checksum of a byte-serial
// data-island packet and latches the decoded AVI fields for the video pipeline.
module avi_info_frame_receiver #(
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int EXPECTED_VERSION = 2,
    parameter int EXPECTED_LENGTH  = 13
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic        packet_start,
    input  logic [7:0]  byte_data,
    output logic        frame_valid,
    output logic        update,
    output logic        checksum_error,
    output logic        header_error,
    output logic [1:0]  video_format,
    output logic        active_format_info_present,
    output logic [1:0]  bar_info,
    output logic [1:0]  scan_info,
    output logic [1:0]  colorimetry,
    output logic [1:0]  picture_aspect_ratio,
    output logic [3:0]  active_format_aspect_ratio,
    output logic        it_content,
    output logic [2:0]  extended_colorimetry,
    output logic [1:0]  rgb_quantization_range,
    output logic [1:0]  non_uniform_picture_scaling,
    output logic [6:0]  video_id_code,
    output logic [1:0]  ycc_quantization_range,
    output logic [1:0]  content_type,
    output logic [3:0]  pixel_repetition,
    output logic [15:0] top_bar_end,
    output logic [15:0] bottom_bar_start,
    output logic [15:0] left_bar_end,
    output logic [15:0] right_bar_start
);

    localparam int         TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0] LAST_IDX     = 5'd30;
    localparam logic [4:0] SUM_LAST_IDX = 5'(3 + EXPECTED_LENGTH);
    localparam logic [7:0] AVI_TYPE     = 8'h82;

    typedef enum logic [1:0] {IDLE, HEADER, BODY, SKIP} state_t;

    typedef struct packed {
        logic [1:0]  video_format;
        logic        active_format_info_present;
        logic [1:0]  bar_info;
        logic [1:0]  scan_info;
        logic [1:0]  colorimetry;
        logic [1:0]  picture_aspect_ratio;
        logic [3:0]  active_format_aspect_ratio;
        logic        it_content;
        logic [2:0]  extended_colorimetry;
        logic [1:0]  rgb_quantization_range;
        logic [1:0]  non_uniform_picture_scaling;
        logic [6:0]  video_id_code;
        logic [1:0]  ycc_quantization_range;
        logic [1:0]  content_type;
        logic [3:0]  pixel_repetition;
        logic [15:0] top_bar_end;
        logic [15:0] bottom_bar_start;
        logic [15:0] left_bar_end;
        logic [15:0] right_bar_start;
    } avi_fields_t;

    state_t        state, state_next;
    logic [4:0]    byte_cnt;
    logic [4:0]    pb_idx;
    logic [TW-1:0] timeout_cnt;
    logic [7:0]    sum, sum_acc;
    logic [7:0]    hb0, hb1;
    logic          start, timed_out, finish, hdr_err_next;
    logic          done_good, done_bad;
    avi_fields_t   shadow, fields;

    assign start     = byte_valid & packet_start;
    assign timed_out = (state != IDLE) && !byte_valid && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign pb_idx    = byte_cnt - 5'd3;
    // Bytes beyond PB[EXPECTED_LENGTH] are still received but do not enter the checksum.
    assign sum_acc   = sum + ((byte_cnt <= SUM_LAST_IDX) ? byte_data : 8'd0);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next   = state;
        hdr_err_next = 1'b0;
        finish       = 1'b0;
        if (start) begin
            state_next = HEADER;
        end else if (byte_valid) begin
            case (state)
                IDLE:   state_next = IDLE;
                HEADER: begin
                    if (byte_cnt == 5'd2) begin
                        if (hb0 == AVI_TYPE && hb1 == 8'(EXPECTED_VERSION) &&
                            byte_data[4:0] == 5'(EXPECTED_LENGTH)) begin
                            state_next = BODY;
                        end else begin
                            state_next   = SKIP;
                            hdr_err_next = (hb0 == AVI_TYPE);
                        end
                    end
                end
                BODY: begin
                    if (byte_cnt == LAST_IDX) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end
                end
                SKIP:    if (byte_cnt == LAST_IDX) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end else if (timed_out) begin
            state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            timeout_cnt    <= '0;
            sum            <= '0;
            hb0            <= '0;
            hb1            <= '0;
            done_good      <= 1'b0;
            done_bad       <= 1'b0;
            update         <= 1'b0;
            checksum_error <= 1'b0;
            header_error   <= 1'b0;
            frame_valid    <= 1'b0;
            fields         <= '0;
        end else begin
            state          <= state_next;
            header_error   <= hdr_err_next;
            done_good      <= finish && (sum_acc == 8'd0);
            done_bad       <= finish && (sum_acc != 8'd0);
            update         <= done_good;
            checksum_error <= done_bad;
            if (done_good) begin
                fields      <= shadow;
                frame_valid <= 1'b1;
            end

            if (start) begin
                byte_cnt <= 5'd1;
                sum      <= byte_data;
                hb0      <= byte_data;
            end else if (state_next == IDLE) begin
                byte_cnt <= '0;
                sum      <= '0;
            end else if (byte_valid) begin
                byte_cnt <= byte_cnt + 5'd1;
                sum      <= sum_acc;
                if (byte_cnt == 5'd1) hb1 <= byte_data;
            end

            if (byte_valid || state == IDLE || timed_out) timeout_cnt <= '0;
            else                                          timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // NOTE: the shadow fields need no reset; a full BODY pass rewrites them before any commit reads them.
    always_ff @(posedge clk_pixel) begin
        if (byte_valid && !packet_start && state == BODY) begin
            case (pb_idx)
                5'd1:  {shadow.video_format, shadow.active_format_info_present,
                        shadow.bar_info, shadow.scan_info} <= byte_data[6:0];
                5'd2:  {shadow.colorimetry, shadow.picture_aspect_ratio,
                        shadow.active_format_aspect_ratio} <= byte_data;
                5'd3:  {shadow.it_content, shadow.extended_colorimetry,
                        shadow.rgb_quantization_range, shadow.non_uniform_picture_scaling} <= byte_data;
                5'd4:  shadow.video_id_code <= byte_data[6:0];
                5'd5:  {shadow.ycc_quantization_range, shadow.content_type,
                        shadow.pixel_repetition} <= byte_data;
                5'd6:  shadow.top_bar_end[7:0]       <= byte_data;
                5'd7:  shadow.top_bar_end[15:8]      <= byte_data;
                5'd8:  shadow.bottom_bar_start[7:0]  <= byte_data;
                5'd9:  shadow.bottom_bar_start[15:8] <= byte_data;
                5'd10: shadow.left_bar_end[7:0]      <= byte_data;
                5'd11: shadow.left_bar_end[15:8]     <= byte_data;
                5'd12: shadow.right_bar_start[7:0]   <= byte_data;
                5'd13: shadow.right_bar_start[15:8]  <= byte_data;
                default: ;
            endcase
        end
    end

    assign video_format                = fields.video_format;
    assign active_format_info_present  = fields.active_format_info_present;
    assign bar_info                    = fields.bar_info;
    assign scan_info                   = fields.scan_info;
    assign colorimetry                 = fields.colorimetry;
    assign picture_aspect_ratio        = fields.picture_aspect_ratio;
    assign active_format_aspect_ratio  = fields.active_format_aspect_ratio;
    assign it_content                  = fields.it_content;
    assign extended_colorimetry        = fields.extended_colorimetry;
    assign rgb_quantization_range      = fields.rgb_quantization_range;
    assign non_uniform_picture_scaling = fields.non_uniform_picture_scaling;
    assign video_id_code               = fields.video_id_code;
    assign ycc_quantization_range      = fields.ycc_quantization_range;
    assign content_type                = fields.content_type;
    assign pixel_repetition            = fields.pixel_repetition;
    assign top_bar_end                 = fields.top_bar_end;
    assign bottom_bar_start            = fields.bottom_bar_start;
    assign left_bar_end                = fields.left_bar_end;
    assign right_bar_start             = fields.right_bar_start;

endmodule

// File: tb/tb_avi_info_frame_receiver.sv
// Scoreboard bench for avi_info_frame_receiver: directed packets push expected
// pulses; a negedge monitor pops and compares whenever the DUT pulses.
module tb_avi_info_frame_receiver;

    localparam int TIMEOUT = 64;

    typedef enum logic [1:0] {EV_UPDATE, EV_CSUM, EV_HDR} ev_t;

    typedef struct packed {
        logic [1:0]  video_format;
        logic        active_format_info_present;
        logic [1:0]  bar_info;
        logic [1:0]  scan_info;
        logic [1:0]  colorimetry;
        logic [1:0]  picture_aspect_ratio;
        logic [3:0]  active_format_aspect_ratio;
        logic        it_content;
        logic [2:0]  extended_colorimetry;
        logic [1:0]  rgb_quantization_range;
        logic [1:0]  non_uniform_picture_scaling;
        logic [6:0]  video_id_code;
        logic [1:0]  ycc_quantization_range;
        logic [1:0]  content_type;
        logic [3:0]  pixel_repetition;
        logic [15:0] top_bar_end;
        logic [15:0] bottom_bar_start;
        logic [15:0] left_bar_end;
        logic [15:0] right_bar_start;
    } tb_fields_t;

    typedef struct {
        ev_t        kind;
        int         due;
        tb_fields_t fields;
        logic       fv;
    } exp_t;

    logic        clk_pixel = 1'b0;
    logic        reset_n, byte_valid, packet_start;
    logic [7:0]  byte_data;
    logic        frame_valid, update, checksum_error, header_error;
    logic [1:0]  video_format, bar_info, scan_info, colorimetry, picture_aspect_ratio;
    logic        active_format_info_present, it_content;
    logic [3:0]  active_format_aspect_ratio, pixel_repetition;
    logic [2:0]  extended_colorimetry;
    logic [1:0]  rgb_quantization_range, non_uniform_picture_scaling;
    logic [6:0]  video_id_code;
    logic [1:0]  ycc_quantization_range, content_type;
    logic [15:0] top_bar_end, bottom_bar_start, left_bar_end, right_bar_start;

    tb_fields_t dut_fields, model_fields, f_default, f_bar;
    logic       model_fv;
    exp_t       exp_q[$];
    logic [7:0] pkt [0:30];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    avi_info_frame_receiver #(
        .TIMEOUT_CYCLES(TIMEOUT), .EXPECTED_VERSION(2), .EXPECTED_LENGTH(13)
    ) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .byte_valid(byte_valid),
        .packet_start(packet_start), .byte_data(byte_data),
        .frame_valid(frame_valid), .update(update), .checksum_error(checksum_error),
        .header_error(header_error), .video_format(video_format),
        .active_format_info_present(active_format_info_present), .bar_info(bar_info),
        .scan_info(scan_info), .colorimetry(colorimetry),
        .picture_aspect_ratio(picture_aspect_ratio),
        .active_format_aspect_ratio(active_format_aspect_ratio), .it_content(it_content),
        .extended_colorimetry(extended_colorimetry),
        .rgb_quantization_range(rgb_quantization_range),
        .non_uniform_picture_scaling(non_uniform_picture_scaling),
        .video_id_code(video_id_code), .ycc_quantization_range(ycc_quantization_range),
        .content_type(content_type), .pixel_repetition(pixel_repetition),
        .top_bar_end(top_bar_end), .bottom_bar_start(bottom_bar_start),
        .left_bar_end(left_bar_end), .right_bar_start(right_bar_start)
    );

    always #5 clk_pixel = ~clk_pixel;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    assign dut_fields = {video_format, active_format_info_present, bar_info, scan_info,
                         colorimetry, picture_aspect_ratio, active_format_aspect_ratio,
                         it_content, extended_colorimetry, rgb_quantization_range,
                         non_uniform_picture_scaling, video_id_code, ycc_quantization_range,
                         content_type, pixel_repetition, top_bar_end, bottom_bar_start,
                         left_bar_end, right_bar_start};

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk_pixel) begin
        exp_t e;
        ev_t  got_kind;
        if (update || checksum_error || header_error) begin
            check("pulse_one_hot", 128'(int'(update) + int'(checksum_error) + int'(header_error)), 128'd1);
            got_kind = update ? EV_UPDATE : (checksum_error ? EV_CSUM : EV_HDR);
            check("pulse_expected", (exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulse_kind", got_kind, e.kind);
                check("pulse_cycle", cyc, e.due);
                check("fields", dut_fields, e.fields);
                check("frame_valid", frame_valid, e.fv);
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        byte_valid   = v;
        packet_start = s;
        byte_data    = d;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_range(input int first, input int last, input bit with_start);
        for (int i = first; i <= last; i++) drive(1'b1, with_start && (i == first), pkt[i]);
    endtask

    task automatic load_header(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2);
        for (int i = 0; i < 31; i++) pkt[i] = 8'h00;
        pkt[0] = h0;
        pkt[1] = h1;
        pkt[2] = h2;
    endtask

    task automatic load_default();
        load_header(8'h82, 8'h02, 8'h0D);
        pkt[3] = 8'h63;
        pkt[5] = 8'h08;
        pkt[7] = 8'h04;
    endtask

    task automatic load_bar();
        load_default();
        pkt[3]  = 8'h5B;
        pkt[4]  = 8'h0C;
        pkt[9]  = 8'hFF;
        pkt[10] = 8'hFF;
        pkt[13] = 8'hFF;
        pkt[14] = 8'hFF;
    endtask

    // Offsets count from the edge before the first driven byte: HB2 pulse +3, PB27 update +32.
    task automatic expect_ev(input ev_t k, input int offset);
        exp_t e;
        e.kind   = k;
        e.due    = cyc + offset;
        e.fields = model_fields;
        e.fv     = model_fv;
        exp_q.push_back(e);
    endtask

    task automatic send_good_default();
        load_default();
        model_fields = f_default;
        model_fv     = 1'b1;
        expect_ev(EV_UPDATE, 32);
        send_range(0, 30, 1'b1);
    endtask

    initial begin
        reset_n      = 1'b0;
        byte_valid   = 1'b0;
        packet_start = 1'b0;
        byte_data    = 8'h00;
        f_default = '0;
        f_default.video_id_code = 7'd4;
        f_default.active_format_aspect_ratio = 4'd8;
        f_bar = f_default;
        f_bar.bar_info        = 2'd3;
        f_bar.top_bar_end     = 16'hFFFF;
        f_bar.left_bar_end    = 16'hFFFF;
        model_fields = '0;
        model_fv     = 1'b0;

        repeat (3) @(posedge clk_pixel);
        #1;
        check("reset_outputs", {update, checksum_error, header_error, frame_valid, dut_fields}, 128'd0);
        reset_n = 1'b1;
        idle(2);

        // Bad checksum: nothing latched yet, then the good frame latches.
        load_default();
        pkt[3] = 8'h64;
        expect_ev(EV_CSUM, 32);
        send_range(0, 30, 1'b1);
        idle(3);
        send_good_default();

        // Bar frame back-to-back with the previous PB27.
        load_bar();
        model_fields = f_bar;
        expect_ev(EV_UPDATE, 32);
        send_range(0, 30, 1'b1);
        idle(3);

        // Restart at byte 10 drops the first packet silently.
        load_default();
        send_range(0, 9, 1'b1);
        send_good_default();
        idle(3);

        // Audio InfoFrame is skipped without a pulse.
        load_header(8'h84, 8'h01, 8'h0A);
        send_range(0, 30, 1'b1);
        send_good_default();
        idle(3);

        // Version mismatch on an AVI type byte.
        load_header(8'h82, 8'h03, 8'h0D);
        expect_ev(EV_HDR, 3);
        send_range(0, 30, 1'b1);
        send_good_default();
        idle(3);

        // Full timeout gap aborts; the resumed bytes lack packet_start and are ignored.
        load_bar();
        send_range(0, 8, 1'b1);
        idle(TIMEOUT);
        send_range(9, 30, 1'b0);
        idle(3);
        send_good_default();
        idle(3);

        // One cycle short of the timeout still completes.
        load_default();
        expect_ev(EV_UPDATE, 32 + TIMEOUT - 1);
        send_range(0, 8, 1'b1);
        idle(TIMEOUT - 1);
        send_range(9, 30, 1'b0);
        idle(3);

        // Reset at PB20 of a good frame clears everything.
        load_default();
        send_range(0, 22, 1'b1);
        reset_n = 1'b0;
        drive(1'b1, 1'b0, pkt[23]);
        reset_n = 1'b1;
        check("reset_mid_packet", {update, checksum_error, header_error, frame_valid, dut_fields}, 128'd0);
        model_fields = '0;
        model_fv     = 1'b0;
        send_range(24, 30, 1'b0);
        idle(3);
        send_good_default();
        idle(5);

        check("queue_drained", exp_q.size(), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avi_info_frame_receiver.md
Name: avi_info_frame_receiver

Overview:
Sink-side parser for the HDMI Auxiliary Video Information (AVI) InfoFrame. It consumes a byte-serial packet stream from the upstream data-island decoder, after TERC4 decode and BCH strip. It validates the header and checksum, then latches the decoded AVI fields for the video pipeline. Packets that are not AVI InfoFrames are consumed and ignored.

Parameters:
TIMEOUT_CYCLES, 64, max clk_pixel cycles between accepted bytes within a packet before abort; must be >= 1
EXPECTED_VERSION, 2, HB1 value accepted
EXPECTED_LENGTH, 13, HB2[4:0] value accepted; also the last PB index covered by the checksum

Ports:
clk_pixel  input  1  pixel clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
byte_valid  input  1  byte_data valid this cycle
packet_start  input  1  qualifies the byte as HB0; only meaningful with byte_valid
byte_data  input  8  order: HB0, HB1, HB2, PB0..PB27 (31 bytes)
frame_valid  output  1  sticky; at least one good AVI frame latched since reset
update  output  1  one-cycle pulse when fields are updated
checksum_error  output  1  one-cycle pulse: AVI header matched, checksum bad
header_error  output  1  one-cycle pulse: HB0=0x82 but version or length mismatch
video_format  output  2  PB1[6:5]
active_format_info_present  output  1  PB1[4]
bar_info  output  2  PB1[3:2]
scan_info  output  2  PB1[1:0]
colorimetry  output  2  PB2[7:6]
picture_aspect_ratio  output  2  PB2[5:4]
active_format_aspect_ratio  output  4  PB2[3:0]
it_content  output  1  PB3[7]
extended_colorimetry  output  3  PB3[6:4]
rgb_quantization_range  output  2  PB3[3:2]
non_uniform_picture_scaling  output  2  PB3[1:0]
video_id_code  output  7  PB4[6:0]
ycc_quantization_range  output  2  PB5[7:6]
content_type  output  2  PB5[5:4]
pixel_repetition  output  4  PB5[3:0]
top_bar_end  output  16  {PB7,PB6}
bottom_bar_start  output  16  {PB9,PB8}
left_bar_end  output  16  {PB11,PB10}
right_bar_start  output  16  {PB13,PB12}

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE, byte counter 0, timeout counter 0, all outputs 0. A reset mid-packet discards the partial packet.
- States:
  - IDLE: waits for byte_valid & packet_start. Non-start bytes are ignored.
  - HEADER: receives HB0..HB2.
  - BODY: receives PB0..PB27 into shadow registers.
  - SKIP: consumes the remaining bytes of a non-AVI or bad-header packet.
  - Completion returns to IDLE.
- byte_valid & packet_start in any state restarts at HB0. The partial packet is dropped with no pulse.
- Header check at HB2: AVI match is HB0=0x82, HB1=EXPECTED_VERSION, HB2[4:0]=EXPECTED_LENGTH. HB2[7:5] is ignored.
  - Match -> BODY.
  - HB0=0x82 but mismatch -> pulse header_error, go to SKIP.
  - HB0!=0x82 -> go to SKIP, no pulse.
- Checksum: 8-bit running sum, mod 256, of HB0..HB2 and PB0..PB[EXPECTED_LENGTH]. PB above EXPECTED_LENGTH are received but excluded.
- Completion is at the acceptance of PB27, 31 bytes total. Outputs update on the next edge, i.e. latency 1 cycle after the PB27 edge.
  - Sum == 0: copy shadow fields to outputs, pulse update, set frame_valid.
  - Sum != 0: pulse checksum_error; outputs and frame_valid keep their old values.
- Ignored bits: PB1[7] and PB4[7].
- Bar fields are latched regardless of bar_info.
- Timeout: the counter resets on each accepted byte and increments while not IDLE and byte_valid=0. Reaching TIMEOUT_CYCLES forces IDLE with no pulse and no update.
- Pulses never overlap: at most one of update, checksum_error or header_error is high per cycle. Each pulse lasts exactly 1 cycle.
- Back-to-back packets: the cycle after PB27 may carry the next HB0 with no gap needed.

Test Plan:
1. Default frame 82 02 0D 63 00 08 00 04 00 then 22x 00 -> update pulse 1 cycle after PB27; video_id_code=4, active_format_aspect_ratio=8, all other fields 0, frame_valid=1.
2. Same frame with PB0=0x64 -> checksum_error pulse; fields still 0, frame_valid=0. Then resend the good frame -> update.
3. Bar frame 82 02 0D 5B 0C 08 00 04 00 FF FF 00 00 FF FF 00 00 then 14x 00 -> bar_info=3, top_bar_end=0xFFFF, bottom_bar_start=0, left_bar_end=0xFFFF, right_bar_start=0.
4. Each of the following, with the default frame sent as the second packet, must yield exactly one update:
   - packet_start reasserted at byte 10 -> first packet dropped silently.
   - 84 01 0A packet (audio InfoFrame) -> no pulse.
   - 82 03 0D packet -> header_error.
5. Gap of TIMEOUT_CYCLES idle cycles after PB5 -> abort, no pulse; resumed bytes without packet_start are ignored. A gap of TIMEOUT_CYCLES-1 completes normally.
6. reset_n low for 1 cycle at PB20 of a good frame after frame 1 was latched -> all outputs 0, no update. The following good frame latches normally.
